// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU front end.
//   - ALU select codes driven on the ALU select input.
//   - Default operand width and register-index width.
//   - is_div0 helper: flags a divide op whose divisor is zero.
package alu_pkg;

  localparam int ALU_WIDTH  = 16;
  localparam int ALU_REG_AW = 4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOT = 4'b0111;
  localparam logic [3:0] ALU_SHL = 4'b1000;
  localparam logic [3:0] ALU_SHR = 4'b1001;
  localparam logic [3:0] ALU_ROL = 4'b1010;
  localparam logic [3:0] ALU_ROR = 4'b1011;
  localparam logic [3:0] ALU_CMP = 4'b1100;

  function automatic logic is_div0(input logic [3:0] sel, input logic divisor_zero);
    return (sel == ALU_DIV) && divisor_zero;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: picks the writeback value over a stored/incoming operand
// when the operand is register-sourced and writeback targets that register.
// Ports:
//   use_reg  - operand comes from a register (immediates never forward)
//   src      - register index of the operand
//   value    - operand value without forwarding
//   wb_valid, wb_rd, wb_data - writeback this cycle
//   result   - operand value after forwarding
module operand_fwd_mux #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 4
) (
  input  logic              use_reg,
  input  logic [REG_AW-1:0] src,
  input  logic [WIDTH-1:0]  value,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  result
);

  assign result = (wb_valid && use_reg && (wb_rd == src)) ? wb_data : value;

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand stage in front of the 16-bit ALU.
// Two-entry skid buffer (main + skid) so decode and ALU stall independently.
// Handshake: a transfer happens on a side in a cycle where valid and ready
// are both high at the rising edge; valid, once raised, holds its payload
// until the transfer. in_ready is a register output (!skid_valid) and does
// not depend on out_ready; outputs come from the main entry only.
// Optional build macro ALU_FWD_EN: writeback forwarding into captured and
// held operands. Without it the wb_* ports are ignored and src/use fields
// are not stored.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   in_valid/in_ready + in_* fields  - decoded op from decode
//   wb_valid, wb_rd, wb_data         - writeback bus (forwarding source)
//   out_valid/out_ready + out_*      - op presented to the ALU
//   out_div0                         - divide op with a zero divisor
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_select,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [REG_AW-1:0] in_src_a,
  input  logic [REG_AW-1:0] in_src_b,
  input  logic              in_use_a,
  input  logic              in_use_b,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_select,
  output logic [WIDTH-1:0]  out_in0,
  output logic [WIDTH-1:0]  out_in1,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_div0
);

  logic              main_valid, skid_valid;
  logic [3:0]        main_sel, skid_sel;
  logic [WIDTH-1:0]  main_a, main_b, skid_a, skid_b;
  logic [REG_AW-1:0] main_rd, skid_rd;

  logic              main_use_a, main_use_b, skid_use_a, skid_use_b;
  logic [REG_AW-1:0] main_src_a, main_src_b, skid_src_a, skid_src_b;
  logic              fwd_wb_valid;

  logic in_fire, out_fire, take_skid, take_in, skid_load;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  // skid refills main when main drains; a full skid already blocks input.
  assign take_skid = out_fire & skid_valid;
  assign take_in   = in_fire & (!main_valid | out_fire);
  assign skid_load = in_fire & main_valid & !out_fire;

  // Next-entry candidates before forwarding.
  logic [3:0]        mn_sel, sk_sel;
  logic [WIDTH-1:0]  mn_a, mn_b, sk_a, sk_b;
  logic [REG_AW-1:0] mn_rd, sk_rd, mn_src_a, mn_src_b, sk_src_a, sk_src_b;
  logic              mn_use_a, mn_use_b, sk_use_a, sk_use_b;

  always_comb begin
    mn_sel = main_sel;  mn_a = main_a;  mn_b = main_b;  mn_rd = main_rd;
    mn_src_a = main_src_a;  mn_src_b = main_src_b;
    mn_use_a = main_use_a;  mn_use_b = main_use_b;
    if (take_skid) begin
      mn_sel = skid_sel;  mn_a = skid_a;  mn_b = skid_b;  mn_rd = skid_rd;
      mn_src_a = skid_src_a;  mn_src_b = skid_src_b;
      mn_use_a = skid_use_a;  mn_use_b = skid_use_b;
    end else if (take_in) begin
      mn_sel = in_select;  mn_a = in_a;  mn_b = in_b;  mn_rd = in_rd;
      mn_src_a = in_src_a;  mn_src_b = in_src_b;
      mn_use_a = in_use_a;  mn_use_b = in_use_b;
    end
  end

  always_comb begin
    sk_sel = skid_sel;  sk_a = skid_a;  sk_b = skid_b;  sk_rd = skid_rd;
    sk_src_a = skid_src_a;  sk_src_b = skid_src_b;
    sk_use_a = skid_use_a;  sk_use_b = skid_use_b;
    if (skid_load) begin
      sk_sel = in_select;  sk_a = in_a;  sk_b = in_b;  sk_rd = in_rd;
      sk_src_a = in_src_a;  sk_src_b = in_src_b;
      sk_use_a = in_use_a;  sk_use_b = in_use_b;
    end
  end

  // Forwarding applies to whatever lands in (or stays in) each entry.
  logic [WIDTH-1:0] mn_a_fwd, mn_b_fwd, sk_a_fwd, sk_b_fwd;

  operand_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_main_a (
    .use_reg(mn_use_a), .src(mn_src_a), .value(mn_a),
    .wb_valid(fwd_wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .result(mn_a_fwd));
  operand_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_main_b (
    .use_reg(mn_use_b), .src(mn_src_b), .value(mn_b),
    .wb_valid(fwd_wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .result(mn_b_fwd));
  operand_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_skid_a (
    .use_reg(sk_use_a), .src(sk_src_a), .value(sk_a),
    .wb_valid(fwd_wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .result(sk_a_fwd));
  operand_fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_skid_b (
    .use_reg(sk_use_b), .src(sk_src_b), .value(sk_b),
    .wb_valid(fwd_wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .result(sk_b_fwd));

`ifdef ALU_FWD_EN
  assign fwd_wb_valid = wb_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_use_a <= 1'b0;  main_use_b <= 1'b0;
      main_src_a <= '0;    main_src_b <= '0;
      skid_use_a <= 1'b0;  skid_use_b <= 1'b0;
      skid_src_a <= '0;    skid_src_b <= '0;
    end else begin
      main_use_a <= mn_use_a;  main_use_b <= mn_use_b;
      main_src_a <= mn_src_a;  main_src_b <= mn_src_b;
      skid_use_a <= sk_use_a;  skid_use_b <= sk_use_b;
      skid_src_a <= sk_src_a;  skid_src_b <= sk_src_b;
    end
  end
`else
  // No src/use storage: held entries never match, capture gate is off.
  logic unused_wb_valid;
  assign unused_wb_valid = wb_valid;
  assign fwd_wb_valid    = 1'b0;
  assign main_use_a = 1'b0;  assign main_use_b = 1'b0;
  assign skid_use_a = 1'b0;  assign skid_use_b = 1'b0;
  assign main_src_a = '0;    assign main_src_b = '0;
  assign skid_src_a = '0;    assign skid_src_b = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;  skid_valid <= 1'b0;
      main_sel <= '0;  main_a <= '0;  main_b <= '0;  main_rd <= '0;
      skid_sel <= '0;  skid_a <= '0;  skid_b <= '0;  skid_rd <= '0;
    end else begin
      if (take_skid || take_in) main_valid <= 1'b1;
      else if (out_fire)        main_valid <= 1'b0;
      if (skid_load)            skid_valid <= 1'b1;
      else if (take_skid)       skid_valid <= 1'b0;
      main_sel <= mn_sel;  main_a <= mn_a_fwd;  main_b <= mn_b_fwd;  main_rd <= mn_rd;
      skid_sel <= sk_sel;  skid_a <= sk_a_fwd;  skid_b <= sk_b_fwd;  skid_rd <= sk_rd;
    end
  end

  assign out_select = main_sel;
  assign out_in0    = main_a;
  assign out_in1    = main_b;
  assign out_rd     = main_rd;
  assign out_div0   = is_div0(main_sel, main_b == '0);

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  in_select = '0;
  logic [15:0] in_a = '0, in_b = '0;
  logic [3:0]  in_src_a = '0, in_src_b = '0, in_rd = '0;
  logic        in_use_a = 1'b0, in_use_b = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic [15:0] wb_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [3:0]  out_select, out_rd;
  logic [15:0] out_in0, out_in1;
  logic        out_div0;

  int checks = 0;
  int errors = 0;

`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rd;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic        use_a;
    logic        use_b;
  } ent_t;

  // Expected contents of the stage, oldest first (at most two ops).
  ent_t exp_q[$];

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
    .in_a(in_a), .in_b(in_b), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_use_a(in_use_a), .in_use_b(in_use_b), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_select(out_select),
    .out_in0(out_in0), .out_in1(out_in1), .out_rd(out_rd), .out_div0(out_div0)
  );

  // Clock / reset: 10 ns period, rising edges at 5, 15, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      check("out_select", 32'(out_select), 32'(exp_q[0].sel));
      check("out_in0", 32'(out_in0), 32'(exp_q[0].a));
      check("out_in1", 32'(out_in1), 32'(exp_q[0].b));
      check("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
      check("out_div0", 32'(out_div0), 32'(exp_q[0].sel == 4'd3 && exp_q[0].b == 16'd0));
    end
  endtask

  // Advance one cycle: update the model from the values being driven,
  // then sample the DUT on the following falling edge.
  task automatic step();
    bit   in_f, out_f;
    ent_t e;
    in_f  = in_valid && (exp_q.size() < 2);
    out_f = (exp_q.size() > 0) && out_ready;
    if (out_f) void'(exp_q.pop_front());
    if (FWD && wb_valid) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].use_a && exp_q[i].src_a == wb_rd) exp_q[i].a = wb_data;
        if (exp_q[i].use_b && exp_q[i].src_b == wb_rd) exp_q[i].b = wb_data;
      end
    end
    if (in_f) begin
      e = '{sel: in_select, a: in_a, b: in_b, rd: in_rd, src_a: in_src_a,
            src_b: in_src_b, use_a: in_use_a, use_b: in_use_b};
      if (FWD && wb_valid && e.use_a && e.src_a == wb_rd) e.a = wb_data;
      if (FWD && wb_valid && e.use_b && e.src_b == wb_rd) e.b = wb_data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Driver helpers.
  task automatic drive_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sa, input logic [3:0] sb,
                          input logic ua, input logic ub, input logic [3:0] rd);
    in_valid = 1'b1; in_select = sel; in_a = a; in_b = b;
    in_src_a = sa; in_src_b = sb; in_use_a = ua; in_use_b = ub; in_rd = rd;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    check("rst_select", 32'(out_select), 32'd0);
    check("rst_in0", 32'(out_in0), 32'd0);
    check("rst_div0", 32'(out_div0), 32'd0);

    // Back-to-back at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_op(4'(i), 16'(i), 16'(2 * i), 4'd0, 4'd0, 1'b0, 1'b0, 4'(i));
      step();
      check("b2b_in0", 32'(out_in0), 32'(i));
      check("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    idle(); step();

    // Stall into the skid, then drain in order.
    out_ready = 1'b0;
    drive_op(4'd1, 16'd10, 16'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1); step();
    drive_op(4'd2, 16'd11, 16'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2); step();
    drive_op(4'd4, 16'd12, 16'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3); step();
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_head", 32'(out_in0), 32'd10);
    out_ready = 1'b1;
    step();
    check("drain_1", 32'(out_in0), 32'd11);
    step();
    check("drain_2", 32'(out_in0), 32'd12);
    idle(); step();

    // Capture forwarding; immediate operand never forwards.
    drive_op(4'd0, 16'h0001, 16'h0055, 4'd3, 4'd3, 1'b1, 1'b0, 4'd7);
    wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 16'hBEEF;
    step();
    check("cap_in0", 32'(out_in0), FWD ? 32'hBEEF : 32'h0001);
    check("cap_in1_imm", 32'(out_in1), 32'h0055);
    idle(); step();

    // Held forwarding into an op sitting in the skid.
    out_ready = 1'b0;
    drive_op(4'd1, 16'h0020, 16'h0021, 4'd1, 4'd2, 1'b0, 1'b1, 4'd1); step();
    drive_op(4'd2, 16'h0030, 16'h0031, 4'd1, 4'd5, 1'b0, 1'b1, 4'd2); step();
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 16'h1234;
    step();
    wb_valid = 1'b0; out_ready = 1'b1;
    step();
    check("held_in1", 32'(out_in1), FWD ? 32'h1234 : 32'h0031);
    idle(); step();

    // Divide-by-zero flag.
    drive_op(4'b0011, 16'd9, 16'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1); step();
    check("div0_set", 32'(out_div0), 32'd1);
    drive_op(4'b0011, 16'd9, 16'd7, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1); step();
    check("div0_clr", 32'(out_div0), 32'd0);
    idle(); step();

    // Randomized traffic with stalls and writeback hits.
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_select = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
      in_a      = 16'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      in_src_a  = 4'($urandom_range(0, 3));
      in_src_b  = 4'($urandom_range(0, 3));
      in_use_a  = 1'($urandom_range(0, 1));
      in_use_b  = 1'($urandom_range(0, 1));
      in_rd     = 4'($urandom_range(0, 15));
      wb_valid  = 1'($urandom_range(0, 1));
      wb_rd     = 4'($urandom_range(0, 3));
      wb_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Reset mid-stream with both entries full.
    idle(); out_ready = 1'b0; step();
    drive_op(4'd5, 16'h00AA, 16'h00BB, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4); step();
    drive_op(4'd6, 16'h00CC, 16'h00DD, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5); step();
    check("pre_rst_full", 32'(in_ready), 32'd0);
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_in0", 32'(out_in0), 32'd0);
    check("rst_mid_rd", 32'(out_rd), 32'd0);
    #1 rst_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    step();
    step();
    check("no_ghost", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
